// File: rtl/cmsdk_mcu_test_ctrl_pkg.sv
// cmsdk_mcu_test_ctrl_pkg: shared state/status encodings and width helper for the run controller.
package cmsdk_mcu_test_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
  // Listed in descending priority after END_NONE.
  typedef enum logic [2:0] {
    END_NONE,
    END_FAIL,
    END_TIMEOUT,
    END_HB_LOST,
    END_PASS
  } end_e;
  function automatic int min1_clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cmsdk_mcu_test_ctrl_hbwdog.sv
// cmsdk_mcu_test_ctrl_hbwdog: heartbeat reload counter and same-cycle expiry flag.
module cmsdk_mcu_test_ctrl_hbwdog
  import cmsdk_mcu_test_ctrl_pkg::*;
#(
  parameter int HB_WINDOW = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_hb,
  output logic o_expire
);
  localparam int HCW = min1_clog2(HB_WINDOW);
  localparam int LIM = HB_WINDOW > 0 ? HB_WINDOW - 1 : 0;
  logic [HCW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_en && !i_hb) ? r_cnt + 1'b1 : '0;
  end
  assign o_expire = i_en && !i_hb && r_cnt == HCW'(LIM);
endmodule

// File: rtl/cmsdk_mcu_test_ctrl.sv
// cmsdk_mcu_test_ctrl: sequenced system reset, run timeout, pass/fail collection and heartbeat watchdog.
module cmsdk_mcu_test_ctrl
  import cmsdk_mcu_test_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int RST_CYC     = 16,
  parameter int TIMEOUT_CYC = 2100000,
  parameter int HB_WINDOW   = 0,
  parameter int AUTO_START  = 1,
  localparam int FCW        = min1_clog2(NUM_CH)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [NUM_CH-1:0] ev_pass,
  input  logic [NUM_CH-1:0] ev_fail,
  input  logic              heartbeat,
  output logic              sys_nrst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [FCW-1:0]    fail_ch,
  output logic              timeout,
  output logic              hb_lost,
  output logic [CNT_W-1:0]  cycles
);
  localparam int RCW = min1_clog2(RST_CYC);
  state_e            r_state;
  logic              r_first;
  logic              r_nrst;
  logic              r_running;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic              r_timeout;
  logic              r_hb_lost;
  logic [FCW-1:0]    r_fail_ch;
  logic [CNT_W-1:0]  r_cycles;
  logic [NUM_CH-1:0] r_mask;
  logic [RCW-1:0]    r_rcnt;
  logic              w_go;
  logic              w_to;
  logic              w_hb_en;
  logic              w_hb_exp;
  logic [NUM_CH-1:0] w_mask;
  logic [FCW-1:0]    w_fail_ch;
  end_e              w_end;
  // r_first marks the first clock after HRESETn release for the automatic start.
  assign w_go = (r_state == ST_IDLE && (start || (AUTO_START != 0 && r_first))) ||
                (r_state == ST_DONE && start);
  assign w_mask  = r_mask | ev_pass;
  assign w_to    = r_cycles == CNT_W'(TIMEOUT_CYC - 1);
  assign w_hb_en = HB_WINDOW != 0 && r_state == ST_RUN;
  always_comb begin
    w_fail_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (ev_fail[i]) w_fail_ch = FCW'(i);
  end
  assign w_end = |ev_fail  ? END_FAIL    :
                 w_to      ? END_TIMEOUT :
                 w_hb_exp  ? END_HB_LOST :
                 &w_mask   ? END_PASS    : END_NONE;
  cmsdk_mcu_test_ctrl_hbwdog #(.HB_WINDOW(HB_WINDOW)) u_hbwdog (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .i_en     (w_hb_en),
    .i_hb     (heartbeat),
    .o_expire (w_hb_exp)
  );
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_first   <= 1'b1;
      r_nrst    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_hb_lost <= 1'b0;
      r_fail_ch <= '0;
      r_cycles  <= '0;
      r_mask    <= '0;
      r_rcnt    <= '0;
    end else begin
      r_first <= 1'b0;
      if (w_go) begin
        r_state   <= ST_RESET;
        r_nrst    <= 1'b0;
        r_running <= 1'b0;
        r_done    <= 1'b0;
        r_pass    <= 1'b0;
        r_fail    <= 1'b0;
        r_timeout <= 1'b0;
        r_hb_lost <= 1'b0;
        r_fail_ch <= '0;
        r_cycles  <= '0;
        r_mask    <= '0;
        r_rcnt    <= '0;
      end else if (r_state == ST_RESET) begin
        r_rcnt <= r_rcnt + 1'b1;
        if (r_rcnt == RCW'(RST_CYC - 1)) begin
          r_state   <= ST_RUN;
          r_nrst    <= 1'b1;
          r_running <= 1'b1;
        end
      end else if (r_state == ST_RUN) begin
        r_cycles <= r_cycles + 1'b1;
        r_mask   <= w_mask;
        if (w_end != END_NONE) begin
          r_state   <= ST_DONE;
          r_running <= 1'b0;
          r_done    <= 1'b1;
          r_fail    <= w_end == END_FAIL;
          r_timeout <= w_end == END_TIMEOUT;
          r_hb_lost <= w_end == END_HB_LOST;
          r_pass    <= w_end == END_PASS;
          r_fail_ch <= w_fail_ch;
        end
      end
    end
  end
  assign sys_nrst = r_nrst;
  assign running  = r_running;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign fail_ch  = r_fail_ch;
  assign timeout  = r_timeout;
  assign hb_lost  = r_hb_lost;
  assign cycles   = r_cycles;
endmodule

// File: tb/tb_cmsdk_mcu_test_ctrl.sv
// tb_cmsdk_mcu_test_ctrl: two configurations driven in lockstep against a timestamp-based reference model.
module tb_cmsdk_mcu_test_ctrl;
  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  logic HRESETn, start, heartbeat;
  logic [3:0] ev_pass, ev_fail;
  logic a_nrst, a_run, a_done, a_pass, a_fail, a_to, a_hbl;
  logic b_nrst, b_run, b_done, b_pass, b_fail, b_to, b_hbl;
  logic [1:0] a_fch, b_fch;
  logic [31:0] a_cyc, b_cyc;
  cmsdk_mcu_test_ctrl #(.NUM_CH(4), .CNT_W(32), .RST_CYC(16), .TIMEOUT_CYC(100), .HB_WINDOW(0), .AUTO_START(1)) u_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .ev_pass(ev_pass), .ev_fail(ev_fail), .heartbeat(heartbeat),
    .sys_nrst(a_nrst), .running(a_run), .done(a_done), .pass(a_pass), .fail(a_fail), .fail_ch(a_fch),
    .timeout(a_to), .hb_lost(a_hbl), .cycles(a_cyc));
  cmsdk_mcu_test_ctrl #(.NUM_CH(4), .CNT_W(32), .RST_CYC(16), .TIMEOUT_CYC(400), .HB_WINDOW(50), .AUTO_START(1)) u_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .ev_pass(ev_pass), .ev_fail(ev_fail), .heartbeat(heartbeat),
    .sys_nrst(b_nrst), .running(b_run), .done(b_done), .pass(b_pass), .fail(b_fail), .fail_ch(b_fch),
    .timeout(b_to), .hb_lost(b_hbl), .cycles(b_cyc));
  typedef struct {
    bit act, fin, auto_p;
    int t0, cyc, lhb;
    logic [3:0] mask;
    logic [5:0] st;
  } m_t;
  typedef struct {
    int pa0, pa1, pa2, pa3, fa;
    logic [3:0] fm;
    int hp, hl;
    logic [5:0] sa;
    int ca;
    logic [5:0] sb;
    int cb;
  } vec_t;
  m_t ma, mb;
  vec_t tbl[8];
  vec_t v;
  int now, checks, errors;
  wire [40:0] w_a = {a_nrst, a_run, a_done, a_pass, a_fail, a_fch, a_to, a_hbl, a_cyc};
  wire [40:0] w_b = {b_nrst, b_run, b_done, b_pass, b_fail, b_fch, b_to, b_hbl, b_cyc};
  // Run timing is tracked by absolute timestamps: RUN entry t0, last heartbeat, elapsed count.
  function automatic m_t step(input m_t m, input int to_cyc, input int hbw, input int t);
    m_t n;
    int k;
    logic [1:0] lo;
    bit f, tmo, hl, p;
    n = m;
    if (!HRESETn) begin
      n = '{default: 0};
      n.auto_p = 1'b1;
      return n;
    end
    if ((!m.act || m.fin) && (start || m.auto_p)) begin
      n.act = 1'b1; n.fin = 1'b0; n.t0 = t + 1 + 16; n.cyc = 0; n.mask = '0; n.lhb = -1; n.st = '0;
    end else if (m.act && !m.fin && t >= m.t0) begin
      k = t - m.t0;
      lo = 2'd0;
      for (int c = 3; c >= 0; c--) if (ev_fail[c]) lo = 2'(c);
      f = |ev_fail;
      tmo = k == to_cyc - 1;
      hl = hbw != 0 && !heartbeat && (k - m.lhb - 1 == hbw - 1);
      n.mask = m.mask | ev_pass;
      p = &n.mask;
      if (heartbeat) n.lhb = k;
      n.cyc = k + 1;
      n.st = f ? {2'b01, lo, 2'b00} : tmo ? 6'b000010 : hl ? 6'b000001 : p ? 6'b100000 : 6'b000000;
      n.fin = f | tmo | hl | p;
    end
    n.auto_p = 1'b0;
    return n;
  endfunction
  function automatic logic [40:0] expv(input m_t m);
    logic nr;
    nr = m.act && now >= m.t0;
    return {nr, nr && !m.fin, m.fin, m.st, 32'(m.cyc)};
  endfunction
  task automatic chk(input string nm, input logic [40:0] got, input logic [40:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h exp %h", nm, now, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge HCLK);
    ma = step(ma, 100, 0, now);
    mb = step(mb, 400, 50, now);
    now++;
    @(negedge HCLK);
    chk("cyc_a", w_a, expv(ma));
    chk("cyc_b", w_b, expv(mb));
  endtask
  task automatic drive(input vec_t s, input int k);
    ev_pass = {s.pa3 == k, s.pa2 == k, s.pa1 == k, s.pa0 == k};
    ev_fail = k == s.fa ? s.fm : 4'h0;
    heartbeat = s.hp == 0 ? 1'b0 : (k > 0 && k % s.hp == 0 && k <= s.hl);
  endtask
  task automatic start_run(input bit rnd);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!a_run && n < 40) begin
      start = rnd && $urandom_range(0, 3) == 0;
      tick();
      n++;
    end
    start = 1'b0;
    chk("run_entry", 41'(a_run && b_run), 41'd1);
  endtask
  task automatic run_vec(input vec_t s, input bit first, input bit rnd);
    int k;
    if (!first) start_run(rnd);
    k = 0;
    while (!(a_done && b_done) && k < 600) begin
      drive(s, k);
      tick();
      k++;
    end
    ev_pass = 4'h0; ev_fail = 4'h0; heartbeat = 1'b0;
    chk("run_end", 41'(a_done && b_done), 41'd1);
    if (!rnd) begin
      chk("end_a", 41'({a_pass, a_fail, a_fch, a_to, a_hbl, a_cyc}), 41'({s.sa, 32'(s.ca)}));
      chk("end_b", 41'({b_pass, b_fail, b_fch, b_to, b_hbl, b_cyc}), 41'({s.sb, 32'(s.cb)}));
    end
  endtask
  task automatic count_reset();
    int n;
    n = 0;
    while (!a_nrst && n < 40) begin
      tick();
      if (!a_nrst) n++;
    end
    chk("rst_len", 41'(n), 41'd16);
  endtask
  initial begin
    HRESETn = 1'b0; start = 1'b0; ev_pass = 4'h0; ev_fail = 4'h0; heartbeat = 1'b0;
    now = 0; checks = 0; errors = 0;
    ma = '{default: 0}; mb = '{default: 0};
    tbl[0] = '{10, 20, 30, 40, -2, 4'h0, 40, 1000, 6'b100000, 41, 6'b100000, 41};
    tbl[1] = '{10, 20, 30, 40, 5, 4'b0110, 40, 1000, 6'b010100, 6, 6'b010100, 6};
    tbl[2] = '{-2, -2, -2, -2, -2, 4'h0, 0, 0, 6'b000010, 100, 6'b000001, 50};
    tbl[3] = '{-2, -2, -2, -2, -2, 4'h0, 40, 120, 6'b000010, 100, 6'b000001, 171};
    tbl[4] = '{170, 170, 170, 170, -2, 4'h0, 40, 120, 6'b000010, 100, 6'b000001, 171};
    tbl[5] = '{-2, -2, -2, -2, 99, 4'b1000, 40, 1000, 6'b011100, 100, 6'b011100, 100};
    tbl[6] = '{5, 5, 5, 8, 8, 4'b0001, 40, 1000, 6'b010000, 9, 6'b010000, 9};
    tbl[7] = '{99, 99, 99, 99, -2, 4'h0, 40, 1000, 6'b000010, 100, 6'b100000, 100};
    repeat (3) tick();
    chk("reset_a", w_a, 41'd0);
    chk("reset_b", w_b, 41'd0);
    HRESETn = 1'b1;
    count_reset();
    for (int i = 0; i < 8; i++) run_vec(tbl[i], i == 0, 1'b0);
    for (int r = 0; r < 20; r++) begin
      v.pa0 = $urandom_range(0, 3) == 0 ? -2 : int'($urandom_range(0, 150));
      v.pa1 = $urandom_range(0, 3) == 0 ? -2 : int'($urandom_range(0, 150));
      v.pa2 = $urandom_range(0, 3) == 0 ? -2 : int'($urandom_range(0, 150));
      v.pa3 = $urandom_range(0, 3) == 0 ? -2 : int'($urandom_range(0, 150));
      v.fa = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 200)) : -2;
      v.fm = 4'($urandom_range(1, 15));
      v.hp = $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(15, 60));
      v.hl = $urandom_range(0, 300);
      v.sa = '0; v.ca = 0; v.sb = '0; v.cb = 0;
      run_vec(v, 1'b0, 1'b1);
    end
    start_run(1'b0);
    for (int k = 0; k < 30; k++) begin
      drive(tbl[0], k);
      tick();
    end
    HRESETn = 1'b0;
    #1;
    chk("async_a", w_a, 41'd0);
    chk("async_b", w_b, 41'd0);
    ev_pass = 4'h0; ev_fail = 4'h0; heartbeat = 1'b0;
    repeat (2) tick();
    HRESETn = 1'b1;
    count_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
